// File: rtl/dp_pkg.sv
// Shared 7-segment definitions: lit-pattern code table and scan-decoder states.
package dp_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    // Lit pattern (GFEDCBA) for hex digits F..0; entry i is the pattern for nibble i.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } dp_state_e;

endpackage

// File: rtl/dp_seg_decode.sv
// Combinational lit-pattern to nibble decoder; unknown patterns give 0 and err.
module dp_seg_decode
    import dp_pkg::*;
(
    input  logic [SEG_W-1:0]    lit,
    output logic [NIBBLE_W-1:0] nibble_c,
    output logic                err_c
);

    // Search the shared table; a pattern matches at most one entry.
    always_comb begin
        nibble_c = '0;
        err_c    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (lit == SEG_TABLE[i]) begin
                nibble_c = NIBBLE_W'(i);
                err_c    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dp_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment bus and emits whole frames.
module dp_scan_decoder
    import dp_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          COM_ACTIVE_LOW = 1'b1,
    parameter int unsigned SETTLE_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC    = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SEG_W-1:0]             seg,
    input  logic [DIGITS-1:0]            com,
    output logic [NIBBLE_W*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]            seg_err,
    output logic                         frame_valid,
    output logic                         stale
);

    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PW = SEG_W + DIGITS;

    logic [SEG_W-1:0]    lit;
    logic [DIGITS-1:0]   sel;
    logic                sel_valid;
    logic [NIBBLE_W-1:0] dec_nib;
    logic                dec_err;

    dp_state_e                         state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d, cnt_nx;
    logic [TW-1:0]                     tcnt_q, tcnt_d;
    logic [PW-1:0]                     pat_q, pat_d;
    logic [DIGITS-1:0]                 seen_q, seen_d;
    logic [DIGITS-1:0][NIBBLE_W-1:0]   slot_val_q, slot_val_d;
    logic [DIGITS-1:0]                 slot_err_q, slot_err_d;
    logic [DIGITS-1:0][NIBBLE_W-1:0]   value_q, value_d;
    logic [DIGITS-1:0]                 seg_err_q, seg_err_d;
    logic                              frame_valid_q, frame_valid_d;
    logic                              stale_q, stale_d;
    logic                              changed, start, cont, sample;

    // Normalise polarity so lit/sel are active-high everywhere below.
    assign lit       = SEG_ACTIVE_LOW ? ~seg : seg;
    assign sel       = COM_ACTIVE_LOW ? ~com : com;
    assign sel_valid = $onehot(sel);

    dp_seg_decode u_dec (
        .lit      (lit),
        .nibble_c (dec_nib),
        .err_c    (dec_err)
    );

    // Settle FSM, frame assembly and blanking timeout.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        pat_d         = {lit, sel};
        seen_d        = seen_q;
        slot_val_d    = slot_val_q;
        slot_err_d    = slot_err_q;
        value_d       = value_q;
        seg_err_d     = seg_err_q;
        frame_valid_d = 1'b0;
        stale_d       = stale_q;
        sample        = 1'b0;

        changed = ({lit, sel} != pat_q);
        start   = sel_valid && ((state_q == ST_IDLE) || changed);
        cont    = sel_valid && (state_q == ST_SETTLE) && !changed;

        // The cycle a new pattern appears counts as the first stable cycle.
        if (start) begin
            cnt_nx = CW'(1);
        end else if (cnt_q == CW'(SETTLE_CYC)) begin
            cnt_nx = cnt_q;
        end else begin
            cnt_nx = cnt_q + CW'(1);
        end

        if (start || cont) begin
            cnt_d = cnt_nx;
            if (cnt_nx >= CW'(SETTLE_CYC)) begin
                sample  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                state_d = ST_SETTLE;
            end
        end else if (!sel_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Publish the completed frame; slots keep any sample taken this cycle.
        if (&seen_q) begin
            frame_valid_d = 1'b1;
            value_d       = slot_val_q;
            seg_err_d     = slot_err_q;
            seen_d        = '0;
        end

        if (sample) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (sel[i]) begin
                    slot_val_d[i] = dec_nib;
                    slot_err_d[i] = dec_err;
                    seen_d[i]     = 1'b1;
                end
            end
        end

        // Long blanking marks the bus stale and drops any partial frame.
        if (sel_valid) begin
            tcnt_d  = '0;
            stale_d = 1'b0;
        end else begin
            if (tcnt_q != TW'(TIMEOUT_CYC)) begin
                tcnt_d = tcnt_q + TW'(1);
            end
            if (tcnt_d == TW'(TIMEOUT_CYC)) begin
                stale_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            pat_q         <= '0;
            seen_q        <= '0;
            slot_val_q    <= '0;
            slot_err_q    <= '0;
            value_q       <= '0;
            seg_err_q     <= '0;
            frame_valid_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            pat_q         <= pat_d;
            seen_q        <= seen_d;
            slot_val_q    <= slot_val_d;
            slot_err_q    <= slot_err_d;
            value_q       <= value_d;
            seg_err_q     <= seg_err_d;
            frame_valid_q <= frame_valid_d;
            stale_q       <= stale_d;
        end
    end

    assign value       = value_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = frame_valid_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_dp_scan_decoder.sv
// Bench for dp_scan_decoder: frame table, corner-case sequences, random scan vs model.
module tb_dp_scan_decoder;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 100;

    // Lit patterns for hex 0..F, GFEDCBA.
    localparam bit [6:0] LIT_OF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  com = 4'hF;
    logic [15:0] value;
    logic [3:0]  seg_err;
    logic        frame_valid;
    logic        stale;

    dp_scan_decoder #(
        .DIGITS         (4),
        .SEG_ACTIVE_LOW (1'b1),
        .COM_ACTIVE_LOW (1'b1),
        .SETTLE_CYC     (SETTLE),
        .TIMEOUT_CYC    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .com         (com),
        .value       (value),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    logic [15:0] last_val;
    logic [3:0]  last_err;

    // Reference model: stable-run length plus per-digit slots.
    int          run_len;
    bit          first;
    bit [10:0]   prev_pat;
    int          inv_cnt;
    bit [3:0]    m_seen;
    bit [3:0]    m_slot [4];
    bit [3:0]    m_slerr;
    bit [15:0]   m_value;
    bit [3:0]    m_err;
    bit          m_fv;
    bit          m_stale;

    typedef struct {
        bit [3:0][6:0] lit;
        bit [15:0]     exp_val;
        bit [3:0]      exp_err;
        int            hold;
    } frame_t;

    frame_t tbl [6];

    function automatic frame_t mk(input bit [6:0] l0, input bit [6:0] l1, input bit [6:0] l2,
                                  input bit [6:0] l3, input bit [15:0] v, input bit [3:0] e,
                                  input int h);
        frame_t f;
        f.lit     = {l3, l2, l1, l0};
        f.exp_val = v;
        f.exp_err = e;
        f.hold    = h;
        return f;
    endfunction

    task automatic model_reset();
        run_len  = 0;
        first    = 1'b1;
        prev_pat = '0;
        inv_cnt  = 0;
        m_seen   = '0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_slerr  = '0;
        m_value  = '0;
        m_err    = '0;
        m_fv     = 1'b0;
        m_stale  = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic [3:0] c);
        bit [6:0]  l;
        bit [3:0]  sl;
        bit        valid;
        bit [10:0] pat;
        int        idx;
        bit [3:0]  nib;
        bit        err;
        l     = ~s;
        sl    = ~c;
        valid = ($countones(sl) == 1);
        pat   = {l, sl};
        if (first || pat != prev_pat) run_len = 1;
        else if (run_len < 1000) run_len++;
        first    = 1'b0;
        prev_pat = pat;
        m_fv     = 1'b0;
        if (m_seen == 4'hF) begin
            m_fv = 1'b1;
            for (int i = 0; i < 4; i++) m_value[4*i +: 4] = m_slot[i];
            m_err  = m_slerr;
            m_seen = '0;
        end
        if (valid && run_len == SETTLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sl[i]) idx = i;
            nib = 4'h0;
            err = 1'b1;
            for (int k = 0; k < 16; k++) if (LIT_OF[k] == l) begin nib = 4'(k); err = 1'b0; end
            m_slot[idx]  = nib;
            m_slerr[idx] = err;
            m_seen[idx]  = 1'b1;
        end
        if (valid) begin
            inv_cnt = 0;
            m_stale = 1'b0;
        end else begin
            if (inv_cnt < int'(TMO)) inv_cnt++;
            if (inv_cnt >= int'(TMO)) begin
                m_stale = 1'b1;
                m_seen  = '0;
            end
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cyc(input logic [6:0] s, input logic [3:0] c);
        seg = s;
        com = c;
        @(posedge clk);
        model_step(s, c);
        #1;
        check_eq("cycle_model", 32'({value, seg_err, frame_valid, stale}),
                 32'({m_value, m_err, m_fv, m_stale}));
        if (frame_valid) begin
            fv_cnt++;
            last_val = value;
            last_err = seg_err;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] c, input int n);
        for (int k = 0; k < n; k++) cyc(s, c);
    endtask

    task automatic show(input int d, input logic [6:0] l, input int n);
        logic [3:0] c;
        c = 4'b0001 << d;
        hold(~l, ~c, n);
    endtask

    task automatic scan_frame(input frame_t f, input string name);
        int n0;
        n0 = fv_cnt;
        for (int d = 0; d < 4; d++) show(d, f.lit[d], f.hold);
        hold(7'h7F, 4'hF, 3);
        if (f.hold >= int'(SETTLE)) begin
            check_eq({name, "_fv_count"}, 32'(fv_cnt - n0), 32'd1);
            check_eq({name, "_value"}, 32'(last_val), 32'(f.exp_val));
            check_eq({name, "_seg_err"}, 32'(last_err), 32'(f.exp_err));
        end else begin
            check_eq({name, "_fv_count"}, 32'(fv_cnt - n0), 32'd0);
        end
    endtask

    initial begin
        int n0;
        tbl[0] = mk(7'h06, 7'h5B, 7'h4F, 7'h66, 16'h4321, 4'b0000, 10);
        tbl[1] = mk(7'h06, 7'h5B, 7'h00, 7'h66, 16'h4021, 4'b0100, 10);
        tbl[2] = mk(7'h77, 7'h7C, 7'h39, 7'h5E, 16'hDCBA, 4'b0000, 10);
        tbl[3] = mk(7'h79, 7'h71, 7'h3F, 7'h7F, 16'h80FE, 4'b0000, 4);
        tbl[4] = mk(7'h06, 7'h06, 7'h06, 7'h06, 16'h0000, 4'b0000, 3);
        tbl[5] = mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 16'h0000, 4'b0000, 6);

        model_reset();
        #12;
        check_eq("reset_outputs", 32'({value, seg_err, frame_valid, stale}), 32'd0);
        #1 rst_n = 1'b1;

        for (int r = 0; r < 6; r++) scan_frame(tbl[r], $sformatf("table%0d", r));

        // Glitch: '7' for 3 cycles is never captured, the settled '5' is.
        n0 = fv_cnt;
        show(0, 7'h07, 3);
        show(0, 7'h6D, 10);
        show(1, 7'h06, 10);
        show(2, 7'h5B, 10);
        show(3, 7'h4F, 10);
        hold(7'h7F, 4'hF, 3);
        check_eq("glitch_fv_count", 32'(fv_cnt - n0), 32'd1);
        check_eq("glitch_value", 32'(last_val), 32'h3215);

        // Two digits selected at once is blanking and leaves the frame intact.
        n0 = fv_cnt;
        show(0, 7'h3F, 10);
        show(1, 7'h6F, 10);
        hold(~7'h66, 4'b1100, 20);
        check_eq("multihot_no_frame", 32'(fv_cnt - n0), 32'd0);
        show(2, 7'h7F, 10);
        show(3, 7'h07, 10);
        hold(7'h7F, 4'hF, 3);
        check_eq("multihot_fv_count", 32'(fv_cnt - n0), 32'd1);
        check_eq("multihot_value", 32'(last_val), 32'h7890);

        // Timeout: stale exactly after TMO blank cycles, partial frame dropped.
        n0 = fv_cnt;
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        hold(7'h7F, 4'hF, int'(TMO) - 1);
        check_eq("stale_before_limit", 32'(stale), 32'd0);
        cyc(7'h7F, 4'hF);
        check_eq("stale_at_limit", 32'(stale), 32'd1);
        show(2, 7'h39, 10);
        check_eq("stale_cleared", 32'(stale), 32'd0);
        show(3, 7'h5E, 10);
        check_eq("timeout_partial_dropped", 32'(fv_cnt - n0), 32'd0);
        show(0, 7'h77, 10);
        show(1, 7'h7C, 10);
        hold(7'h7F, 4'hF, 3);
        check_eq("timeout_fv_count", 32'(fv_cnt - n0), 32'd1);
        check_eq("timeout_value", 32'(last_val), 32'hDCBA);

        // Asynchronous reset mid-frame, not aligned to the clock.
        show(0, 7'h6D, 10);
        show(1, 7'h7D, 10);
        show(2, 7'h07, 10);
        seg = ~7'h7F;
        com = ~4'b1000;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("reset_async", 32'({value, seg_err, frame_valid, stale}), 32'd0);
        model_reset();
        #10 rst_n = 1'b1;
        n0 = fv_cnt;
        show(3, 7'h7F, 10);
        check_eq("reset_needs_all", 32'(fv_cnt - n0), 32'd0);
        show(0, 7'h6F, 10);
        show(1, 7'h77, 10);
        show(2, 7'h7C, 10);
        hold(7'h7F, 4'hF, 3);
        check_eq("reset_fv_count", 32'(fv_cnt - n0), 32'd1);
        check_eq("reset_value", 32'(last_val), 32'h8BA9);

        // Random scanning with illegal patterns, blanking and long idles.
        for (int k = 0; k < 400; k++) begin
            logic [6:0] l;
            logic [3:0] c;
            int r;
            if ($urandom_range(0, 39) == 0) begin
                hold(7'h7F, 4'hF, int'(TMO) + 5);
            end else begin
                l = ($urandom_range(0, 7) == 0) ? 7'($urandom) : LIT_OF[$urandom_range(0, 15)];
                r = $urandom_range(0, 9);
                if (r < 7)       c = ~(4'b0001 << $urandom_range(0, 3));
                else if (r == 7) c = 4'hF;
                else if (r == 8) c = 4'($urandom);
                else             c = 4'h0;
                hold(~l, c, $urandom_range(1, 8));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
